// File: rtl/pipelined_shifter.sv
// pipelined_shifter: parametrised SLL/SRL/SRA/ROR barrel shifter built
// from log2(WIDTH) stages, with a register after every STAGE_GRP stages.
// Ports: i_clk, i_rst (sync, active-high);
//   input side  i_valid/o_ready with i_a (operand), i_b (amount),
//               i_op (00 SLL, 01 SRL, 10 SRA, 11 ROR), i_tag (sideband);
//   output side o_valid/i_ready with o_data, o_tag, o_zero (o_data == 0).
module pipelined_shifter #(
    parameter int WIDTH     = 32,
    parameter int SHW       = $clog2(WIDTH),
    parameter int STAGE_GRP = 1,
    parameter int TAG_W     = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [SHW-1:0]   i_b,
    input  logic [1:0]       i_op,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_zero
);

    localparam int NREG = (SHW + STAGE_GRP - 1) / STAGE_GRP;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef logic [WIDTH-1:0] word_t;

    // One barrel stage: shift by 2^k. SRA fills from the sign bit taken
    // at the input, not from the current MSB of the partial result.
    function automatic word_t stage_f(
        input word_t      d,
        input logic [1:0] op,
        input logic       sgn,
        input int         k
    );
        word_t r;
        int    s;
        s = 1 << k;
        r = d;
        unique case (op)
            OP_SLL: r = d << s;
            OP_SRL: r = d >> s;
            OP_SRA: r = (d >> s) | (sgn ? ~({WIDTH{1'b1}} >> s) : '0);
            OP_ROR: r = (d >> s) | (d << (WIDTH - s));
        endcase
        return r;
    endfunction

    // Single global advance: every slot moves together, bubbles included.
    logic adv;
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    for (genvar r = 0; r < NREG; r++) begin : g_slot
        // Stages [K0, K1) sit in front of this slot's register.
        localparam int K0   = r * STAGE_GRP;
        localparam int K1   = (K0 + STAGE_GRP < SHW) ? K0 + STAGE_GRP : SHW;
        // Amount bits still pending when entering this group.
        localparam int SW   = SHW - K0;
        localparam bit LAST = (r == NREG - 1);

        word_t            src_data;
        logic [SW-1:0]    src_amt;
        logic [1:0]       src_op;
        logic             src_sgn;
        logic [TAG_W-1:0] src_tag;
        logic             src_vld;

        word_t            data_d;
        word_t            data_q;
        logic [TAG_W-1:0] tag_q;
        logic             vld_q;

        if (r == 0) begin : g_head
            assign src_data = i_a;
            assign src_amt  = i_b;
            assign src_op   = i_op;
            assign src_sgn  = i_a[WIDTH-1];
            assign src_tag  = i_tag;
            assign src_vld  = i_valid & adv;
        end else begin : g_link
            assign src_data = g_slot[r-1].data_q;
            assign src_amt  = g_slot[r-1].g_mid.amt_q;
            assign src_op   = g_slot[r-1].g_mid.op_q;
            assign src_sgn  = g_slot[r-1].g_mid.sgn_q;
            assign src_tag  = g_slot[r-1].tag_q;
            assign src_vld  = g_slot[r-1].vld_q;
        end

        for (genvar k = K0; k < K1; k++) begin : g_stage
            word_t din;
            word_t dout;
            if (k == K0) begin : g_first
                assign din = src_data;
            end else begin : g_chain
                assign din = g_stage[k-1].dout;
            end
            assign dout = src_amt[k-K0]
                        ? stage_f(din, src_op, src_sgn, k)
                        : din;
        end

        assign data_d = g_stage[K1-1].dout;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                tag_q  <= '0;
            end else if (adv) begin
                vld_q  <= src_vld;
                data_q <= data_d;
                tag_q  <= src_tag;
            end
        end

        // Control that later groups still need; the last slot has none.
        // Consumed amount bits are dropped so each register only keeps
        // the bits of the groups downstream of it.
        if (!LAST) begin : g_mid
            logic [SW-STAGE_GRP-1:0] amt_q;
            logic [1:0]              op_q;
            logic                    sgn_q;

            always_ff @(posedge i_clk) begin
                if (adv) begin
                    amt_q <= src_amt[SW-1:STAGE_GRP];
                    op_q  <= src_op;
                    sgn_q <= src_sgn;
                end
            end
        end
    end

    // Zero flag is registered alongside the final data so the output
    // carries no reduction tree.
    logic zero_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            zero_q <= 1'b1;
        end else if (adv) begin
            zero_q <= (g_slot[NREG-1].data_d == '0);
        end
    end

    assign o_valid = g_slot[NREG-1].vld_q;
    assign o_data  = g_slot[NREG-1].data_q;
    assign o_tag   = g_slot[NREG-1].tag_q;
    assign o_zero  = zero_q;

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the combinational 32-bit arithmetic right shifter used by the RV32I ALU.
- Performs logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand.
- Log-stage barrel network with pipeline registers inserted every STAGE_GRP stages.
- Valid/ready handshake on both sides; sits between the ALU issue and writeback paths for multicycle execute configurations.

Parameters:
WIDTH, 32, operand width; power of two, 8..64.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
STAGE_GRP, 1, barrel stages per pipeline register; 1..SHW.
TAG_W, 5, sideband tag width (e.g. rd index), carried unchanged.

Ports:
i_clk  in  1  clock, all logic rising-edge.
i_rst  in  1  synchronous reset, active-high.
i_valid  in  1  input operation valid.
o_ready  out  1  block can accept an input this cycle.
i_a  in  WIDTH  operand.
i_b  in  SHW  shift amount; only the low SHW bits of the architectural operand are supplied.
i_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
i_tag  in  TAG_W  sideband, returned with the result.
o_valid  out  1  result valid.
i_ready  in  1  downstream accepts the result.
o_data  out  WIDTH  shifted result.
o_tag  out  TAG_W  tag of the result.
o_zero  out  1  o_data == 0.

Behaviour:
- Depth and latency:
  - NREG = ceil(SHW / STAGE_GRP).
  - Latency is exactly NREG cycles from input handshake to o_valid with no stalls; for WIDTH=32, STAGE_GRP=1 the latency is 5.
- Stages:
  - Stage k (k = 0..SHW-1) shifts by 2^k when i_b[k] = 1.
  - The amount bit, op and tag travel with the data through every register.
- Fill rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the sign bit captured at input (i_a[WIDTH-1]).
  - ROR wraps the low bits into the MSBs.
  - i_b = 0 returns i_a unchanged for every op.
- Pipeline control:
  - Each register slot has a valid bit.
  - Global advance enable: adv = !o_valid | i_ready.
  - o_ready = adv (combinational; no other dependency on i_valid).
  - When adv = 1, every slot loads from its predecessor; slot 0 loads i_valid & o_ready together with the operand.
  - When adv = 0, all slots hold data and valid.
  - Bubbles are not compressed.
- Output:
  - o_data, o_tag and o_zero come from the last slot.
  - These outputs stay stable while o_valid = 1 and i_ready = 0.
  - o_zero is computed in the last stage before the final register, so it is not a combinational reduction at the output.
- Throughput:
  - One result per cycle when i_ready is held at 1.
  - Simultaneous input accept and output drain in the same cycle is legal and required.
- Reset:
  - i_rst = 1 clears all valid bits at the next edge.
  - After reset: o_valid = 0, o_data = 0, o_tag = 0, o_zero = 1, o_ready = 1.
  - Reset mid-operation discards all in-flight operations; none appear at the output afterwards.
  - Data registers may also be cleared; the bench checks them only when o_valid = 1.
- Don't-care inputs:
  - i_a, i_b, i_op and i_tag are ignored when i_valid = 0 or o_ready = 0.
- Ordering:
  - Results emerge strictly in issue order, with tags intact.

Test Plan:
1. Reset, then a single SRA with i_a = 32'h8000_0010, i_b = 4, tag = 3 -> after exactly 5 cycles o_valid = 1, o_data = 32'hF800_0001, o_tag = 3, o_zero = 0.
2. One op each, back-to-back, on i_a = 32'h8765_4321, i_b = 8, with i_ready = 1:
   - SLL -> 32'h6543_2100
   - SRL -> 32'h0087_6543
   - SRA -> 32'hFF87_6543
   - ROR -> 32'h2187_6543
   - Required: four consecutive o_valid cycles, in order.
3. Boundary cases:
   - SRA of 32'h8000_0000 by 31 -> 32'hFFFF_FFFF.
   - SRL of the same operand by 31 -> 32'h0000_0001.
   - Any op with i_b = 0 -> i_a unchanged.
   - SLL of 32'h1 by 31 then SLL by 1 of 32'h8000_0000 -> o_zero = 1 on the second.
4. Backpressure:
   - Stream 8 ops with i_ready held 0 for 6 cycles mid-stream.
   - Required: o_ready drops when the output slot is full; o_data/o_tag hold steady; no loss or duplication; all 8 tags emerge in order once i_ready = 1.
5. Reset mid-stream:
   - Issue 3 ops, assert i_rst for 1 cycle at cycle 2.
   - Required: o_valid stays 0 for the next 10 cycles; a fresh op then completes with 5-cycle latency.
6. Parameter sweep:
   - WIDTH = 16, STAGE_GRP = 2 (latency 2): random ops checked against a reference model.
   - WIDTH = 64, STAGE_GRP = 6 (latency 1): random ops checked against a reference model.
   - Run 10k ops each with random i_valid/i_ready; zero mismatches required.
